// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//
// Host-to-device PS/2 transmitter. Sends one command byte to the attached
// device over the open-drain ps2_clk/ps2_data pair. The sequence is: inhibit
// the clock, request-to-send (start bit), then shift 8 data bits LSB-first,
// odd parity and stop on device-generated clock falls. Finally the device
// ACK is sampled and the block waits for the bus to return to idle.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        asynchronous, active-low reset
//   start        request to send; accepted only while busy=0
//   data[7:0]    byte to send, sampled in the cycle start is accepted
//   ps2_clk_in   raw PS/2 clock line (asynchronous to clk)
//   ps2_data_in  raw PS/2 data line (asynchronous to clk)
//   ps2_clk_oe   1 = pull ps2_clk low, 0 = release
//   ps2_data_oe  1 = pull ps2_data low, 0 = release
//   busy         high from the cycle after start is accepted until done
//   done         one-cycle pulse when the transaction ends
//   ack_err      valid with done: 1 = no ACK (or timeout); held until next start
//
// Parameters:
//   INHIBIT_CYCLES  clk cycles ps2_clk is held low before request-to-send (>= 2)
//   TIMEOUT_CYCLES  watchdog limit between device clock falls
//
// Optional feature macro: PS2_TX_TIMEOUT_EN
//   When defined, a watchdog aborts the transaction if no device clock fall
//   arrives within TIMEOUT_CYCLES while in SEND, ACK or WAIT_IDLE.
// ---------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    localparam int InhW = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } txState_t;

    txState_t         r_state;
    txState_t         w_nextState;
    logic [InhW-1:0]  r_inhCnt;
    logic [InhW-1:0]  w_nextInhCnt;
    logic [3:0]       r_bitCnt;
    logic [3:0]       w_nextBitCnt;
    logic [8:0]       r_shift;
    logic [8:0]       w_nextShift;
    logic             r_clkOe;
    logic             w_nextClkOe;
    logic             r_dataOe;
    logic             w_nextDataOe;
    logic             r_busy;
    logic             w_nextBusy;
    logic             r_done;
    logic             w_nextDone;
    logic             r_ackErr;
    logic             w_nextAckErr;

    logic [1:0]       r_clkSync;
    logic [1:0]       r_dataSync;
    logic             r_clkPrev;
    logic             w_fall;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WdW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT_CYCLES);

    logic [WdW-1:0]   r_wdog;
    logic [WdW-1:0]   w_nextWdog;
    logic             w_watched;
`else
    logic             w_unusedTimeout;
    assign w_unusedTimeout = (TIMEOUT_CYCLES > 0);
`endif

    // Two-flop synchronizers plus a delayed copy of the clock for fall
    // detection. They reset to 1 (idle bus level) so that leaving reset does
    // not look like a device clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clkSync  <= 2'b11;
            r_dataSync <= 2'b11;
            r_clkPrev  <= 1'b1;
        end else begin
            r_clkSync  <= {r_clkSync[0], ps2_clk_in};
            r_dataSync <= {r_dataSync[0], ps2_data_in};
            r_clkPrev  <= r_clkSync[1];
        end
    end

    assign w_fall = r_clkPrev & ~r_clkSync[1];

    // State register and all registered outputs. The line enables come
    // straight from flops so the open-drain drivers never see a glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_inhCnt <= '0;
            r_bitCnt <= '0;
            r_shift  <= '0;
            r_clkOe  <= 1'b0;
            r_dataOe <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ackErr <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_inhCnt <= w_nextInhCnt;
            r_bitCnt <= w_nextBitCnt;
            r_shift  <= w_nextShift;
            r_clkOe  <= w_nextClkOe;
            r_dataOe <= w_nextDataOe;
            r_busy   <= w_nextBusy;
            r_done   <= w_nextDone;
            r_ackErr <= w_nextAckErr;
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog counter; cleared outside the device-clocked states.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= w_nextWdog;
        end
    end
`endif

    // Next-state and next-output logic. The shift register is pre-loaded
    // with {parity, data}; each device fall in SEND drives the inverse of the
    // LSB (pulling low sends a 0) and shifts right. The 10th fall releases
    // data for the stop bit, the 11th samples the device ACK.
    always_comb begin
        w_nextState  = r_state;
        w_nextInhCnt = r_inhCnt;
        w_nextBitCnt = r_bitCnt;
        w_nextShift  = r_shift;
        w_nextClkOe  = r_clkOe;
        w_nextDataOe = r_dataOe;
        w_nextBusy   = r_busy;
        w_nextDone   = 1'b0;
        w_nextAckErr = r_ackErr;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextShift  = {~^data, data};
                    w_nextAckErr = 1'b0;
                    w_nextBusy   = 1'b1;
                    w_nextClkOe  = 1'b1;
                    w_nextDataOe = 1'b0;
                    w_nextInhCnt = '0;
                    w_nextBitCnt = '0;
                    w_nextState  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (r_inhCnt == InhLast) begin
                    w_nextDataOe = 1'b1;
                    w_nextState  = REQ;
                end else begin
                    w_nextInhCnt = r_inhCnt + 1'b1;
                end
            end
            REQ: begin
                w_nextClkOe  = 1'b0;
                w_nextBitCnt = '0;
                w_nextState  = SEND;
            end
            SEND: begin
                if (w_fall) begin
                    w_nextBitCnt = r_bitCnt + 1'b1;
                    if (r_bitCnt == 4'd9) begin
                        w_nextDataOe = 1'b0;
                        w_nextState  = ACK;
                    end else begin
                        w_nextDataOe = ~r_shift[0];
                        w_nextShift  = {1'b0, r_shift[8:1]};
                    end
                end
            end
            ACK: begin
                if (w_fall) begin
                    w_nextBitCnt = r_bitCnt + 1'b1;
                    w_nextAckErr = r_dataSync[1];
                    w_nextState  = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (r_clkSync[1] && r_dataSync[1]) begin
                    w_nextDone  = 1'b1;
                    w_nextBusy  = 1'b0;
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        w_watched  = (r_state == SEND) || (r_state == ACK) || (r_state == WAIT_IDLE);
        w_nextWdog = '0;
        if (w_watched) begin
            if (r_wdog == WdLimit) begin
                w_nextClkOe  = 1'b0;
                w_nextDataOe = 1'b0;
                w_nextAckErr = 1'b1;
                w_nextDone   = 1'b1;
                w_nextBusy   = 1'b0;
                w_nextState  = IDLE;
            end else if (!w_fall && (w_nextState == r_state)) begin
                w_nextWdog = r_wdog + 1'b1;
            end
        end
`endif
    end

    assign ps2_clk_oe  = r_clkOe;
    assign ps2_data_oe = r_dataOe;
    assign busy        = r_busy;
    assign done        = r_done;
    assign ack_err     = r_ackErr;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
//
// Directed testbench for ps2_host_tx. A behavioural PS/2 device drives the
// clock and data lines (wired-AND with the host's pull-downs), samples the
// line level just before each fall and optionally ACKs on the 11th fall.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

    localparam int InhCycles = 20;
    localparam int ToCycles  = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data = 8'h00;
    logic       devClk = 1'b1;
    logic       devData = 1'b1;
    logic       ps2ClkLine;
    logic       ps2DataLine;
    logic       ps2ClkOe;
    logic       ps2DataOe;
    logic       busy;
    logic       done;
    logic       ackErr;

    int checkCount = 0;
    int errorCount = 0;

    int cycleNum = 0;
    int clkOeCycles = 0;
    int reqCycles = 0;
    int doneCount = 0;
    int doneCycle = 0;
    logic doneAckErr = 1'b0;
    logic doneBusy = 1'b0;
    int lastFallCycle = 0;

    ps2_host_tx #(
        .INHIBIT_CYCLES(InhCycles),
        .TIMEOUT_CYCLES(ToCycles)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .data        (data),
        .ps2_clk_in  (ps2ClkLine),
        .ps2_data_in (ps2DataLine),
        .ps2_clk_oe  (ps2ClkOe),
        .ps2_data_oe (ps2DataOe),
        .busy        (busy),
        .done        (done),
        .ack_err     (ackErr)
    );

    // Open-drain bus: either side pulling low wins.
    assign ps2ClkLine  = devClk & ~ps2ClkOe;
    assign ps2DataLine = devData & ~ps2DataOe;

    always #5 clk = ~clk;

    // Free-running cycle counter for latency measurements.
    always @(posedge clk) begin
        cycleNum <= cycleNum + 1;
    end

    // Bus monitor: counts inhibit/request cycles and captures done events.
    always @(negedge clk) begin
        if (ps2ClkOe) clkOeCycles <= clkOeCycles + 1;
        if (ps2ClkOe && ps2DataOe) reqCycles <= reqCycles + 1;
        if (done) begin
            doneAckErr <= ackErr;
            doneBusy   <= busy;
            doneCycle  <= cycleNum;
            doneCount  <= doneCount + 1;
        end
    end

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One-cycle start pulse with the given byte.
    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        start = 1'b1;
        data  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for a done pulse beyond the given count.
    task automatic waitDone(input int baseDone, input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (doneCount != baseDone) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("done_seen", 32'(seen), 32'd1);
    endtask

    // Device model. bits[j] is the data line level just before fall j+1.
    task automatic runDevice(input int nFalls, input bit ackLow, input int startAt,
                             input int resetAt, output logic [10:0] bits);
        bit found;
        bits  = '0;
        found = 1'b0;
        for (int i = 0; i < InhCycles + 50; i++) begin
            @(negedge clk);
            if (busy && !ps2ClkOe) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("send_entry", 32'(found), 32'd1);
        if (!found) return;
        repeat (8) @(negedge clk);
        for (int j = 0; j < nFalls; j++) begin
            bits[j] = ps2DataLine;
            if (j == 10 && ackLow) devData = 1'b0;
            devClk = 1'b0;
            lastFallCycle = cycleNum;
            if (j + 1 == resetAt) begin
                checkOutput("pre_rst_data_oe", 32'(ps2DataOe), 32'd1);
                #1 reset = 1'b0;
                #1;
                checkOutput("rst_clk_oe", 32'(ps2ClkOe), 32'd0);
                checkOutput("rst_data_oe", 32'(ps2DataOe), 32'd0);
                checkOutput("rst_busy", 32'(busy), 32'd0);
                repeat (3) @(negedge clk);
                devClk  = 1'b1;
                devData = 1'b1;
                repeat (5) @(negedge clk);
                reset = 1'b1;
                repeat (5) @(negedge clk);
                return;
            end
            repeat (10) @(negedge clk);
            devClk  = 1'b1;
            devData = 1'b1;
            if (j == startAt) begin
                applyStimulus(8'hFF);
                repeat (8) @(negedge clk);
            end else begin
                repeat (10) @(negedge clk);
            end
        end
    endtask

    // Main sequence.
    initial begin
        logic [10:0] bits;
        int baseDone;
        int baseOe;
        int baseReq;

        reset = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("rst_state_clk_oe", 32'(ps2ClkOe), 32'd0);
        checkOutput("rst_state_data_oe", 32'(ps2DataOe), 32'd0);
        checkOutput("rst_state_busy", 32'(busy), 32'd0);
        checkOutput("rst_state_done", 32'(done), 32'd0);
        checkOutput("rst_state_ack_err", 32'(ackErr), 32'd0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // 0xED with ACK: start 0, data LSB-first, parity 1, stop 1.
        baseDone = doneCount;
        baseOe   = clkOeCycles;
        baseReq  = reqCycles;
        applyStimulus(8'hED);
        checkOutput("ed_busy", 32'(busy), 32'd1);
        runDevice(11, 1'b1, -1, -1, bits);
        waitDone(baseDone, 60);
        checkOutput("ed_bits", 32'(bits), 32'h7DA);
        checkOutput("ed_clk_oe_cycles", 32'(clkOeCycles - baseOe), 32'(InhCycles + 1));
        checkOutput("ed_req_cycles", 32'(reqCycles - baseReq), 32'd1);
        checkOutput("ed_ack_err", 32'(doneAckErr), 32'd0);
        checkOutput("ed_busy_at_done", 32'(doneBusy), 32'd0);
        @(negedge clk);
        checkOutput("ed_busy_after", 32'(busy), 32'd0);
        checkOutput("ed_done_count", 32'(doneCount - baseDone), 32'd1);

        // 0x01 without ACK: parity 0, ack_err must be set and held.
        baseDone = doneCount;
        applyStimulus(8'h01);
        runDevice(11, 1'b0, -1, -1, bits);
        waitDone(baseDone, 60);
        checkOutput("x01_bits", 32'(bits), 32'h402);
        checkOutput("x01_ack_err", 32'(doneAckErr), 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("x01_ack_err_hold", 32'(ackErr), 32'd1);

        // 0xA5 with a start/0xFF pulse mid-SEND that must be ignored.
        baseDone = doneCount;
        applyStimulus(8'hA5);
        checkOutput("a5_ack_err_cleared", 32'(ackErr), 32'd0);
        runDevice(11, 1'b1, 3, -1, bits);
        waitDone(baseDone, 60);
        checkOutput("a5_bits", 32'(bits), 32'h74A);
        checkOutput("a5_ack_err", 32'(doneAckErr), 32'd0);
        repeat (40) @(negedge clk);
        checkOutput("a5_done_count", 32'(doneCount - baseDone), 32'd1);
        checkOutput("a5_busy_after", 32'(busy), 32'd0);

        // 0xF4 aborted by reset at the 5th fall, then sent again normally.
        baseDone = doneCount;
        applyStimulus(8'hF4);
        runDevice(11, 1'b1, -1, 5, bits);
        checkOutput("f4_abort_no_done", 32'(doneCount - baseDone), 32'd0);
        checkOutput("f4_abort_busy", 32'(busy), 32'd0);
        baseDone = doneCount;
        applyStimulus(8'hF4);
        runDevice(11, 1'b1, -1, -1, bits);
        waitDone(baseDone, 60);
        checkOutput("f4_bits", 32'(bits), 32'h5E8);
        checkOutput("f4_ack_err", 32'(doneAckErr), 32'd0);

        // 0x3C: device stops after 4 falls.
        baseDone = doneCount;
        applyStimulus(8'h3C);
        runDevice(4, 1'b0, -1, -1, bits);
        checkOutput("stall_bits", 32'(bits), 32'h008);
`ifdef PS2_TX_TIMEOUT_EN
        waitDone(baseDone, 300);
        checkOutput("to_latency_ok",
                    32'((doneCycle - lastFallCycle >= ToCycles) &&
                        (doneCycle - lastFallCycle <= ToCycles + 10)), 32'd1);
        checkOutput("to_ack_err", 32'(doneAckErr), 32'd1);
        checkOutput("to_busy", 32'(doneBusy), 32'd0);
        @(negedge clk);
        checkOutput("to_clk_oe", 32'(ps2ClkOe), 32'd0);
        checkOutput("to_data_oe", 32'(ps2DataOe), 32'd0);
`else
        repeat (10000) @(negedge clk);
        checkOutput("stall_busy", 32'(busy), 32'd1);
        checkOutput("stall_no_done", 32'(doneCount - baseDone), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("stall_recover_busy", 32'(busy), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter: the send side of the PS/2 link whose 11-bit frames the keyboard receive path counts.
- Sends one command byte to the device (e.g. 0xED set-LEDs) over the open-drain ps2_clk/ps2_data pair.
- Performs inhibit/request-to-send, shifts 8 data bits LSB-first plus odd parity and stop on device-generated clock edges, then checks the device ACK.
- Sits beside the receive path in the keyboard interface; the top level ties the *_oe outputs to tri-state drivers that pull low.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before request-to-send (100 us at 50 MHz); minimum 2
TIMEOUT_CYCLES, 750000, watchdog limit in clk cycles between device clock falling edges (15 ms at 50 MHz); used only with PS2_TX_TIMEOUT_EN

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request to send data; accepted only when busy=0
data  input  8  byte to send; sampled in the cycle start is accepted
ps2_clk_in  input  1  raw PS/2 clock line; asynchronous to clk
ps2_data_in  input  1  raw PS/2 data line; asynchronous to clk
ps2_clk_oe  output  1  1 = pull ps2_clk low; 0 = release
ps2_data_oe  output  1  1 = pull ps2_data low; 0 = release
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when the transaction ends (success or error)
ack_err  output  1  valid with done: 1 = device did not ACK (or timeout); holds until next start

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, ack_err=0. Bit counter and shift register are cleared. Reset mid-frame releases both lines immediately.
- Input conditioning: ps2_clk_in and ps2_data_in each pass through a 2-flop synchronizer. Falling edge fall = previous synced clk is 1 and current is 0. Edge detection adds 3 cycles of latency.
- Shift register holds {parity, data[7:0]}; parity = ~^data (odd parity).
- IDLE: start=1 latches data, clears ack_err, and moves to INHIBIT. busy=1 from the next cycle.
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles, then REQ.
- REQ: one cycle with ps2_clk_oe=1 and ps2_data_oe=1 (start bit 0). Then SEND with ps2_clk_oe=0 and data_oe still 1.
- SEND: a 4-bit edge counter k counts falls.
  - k=1..8: ps2_data_oe = ~data[k-1].
  - k=9: ps2_data_oe = ~parity.
  - k=10: ps2_data_oe=0 (stop bit); go to ACK.
  - Outputs update the cycle after fall is detected.
- ACK: on the 11th fall, sample synced data. 0 means ACK ok; 1 sets ack_err=1. Go to WAIT_IDLE.
- WAIT_IDLE: wait until synced clk=1 and data=1 in the same cycle. Then pulse done for 1 cycle, set busy=0, return to IDLE.
- start while busy=1 is ignored; no queuing.
- Falls seen in IDLE, INHIBIT or REQ are ignored. The counter is reset on entry to SEND.
- ps2_clk_oe and ps2_data_oe are registered outputs (no combinational glitches).
- At most 13 cycles pass between the device's 11th fall and done, once the lines are idle.

Optional Feature:
PS2_TX_TIMEOUT_EN
- Defined: a watchdog counter runs in SEND, ACK and WAIT_IDLE. It resets on every fall (and on state entry).
  - If it reaches TIMEOUT_CYCLES, both oe outputs drop to 0 the next cycle, ack_err=1, done pulses, busy=0, and the state returns to IDLE.
- Undefined: no watchdog logic; the FSM waits indefinitely for device edges. TIMEOUT_CYCLES is unused.

Test Plan:
- Send 0xED; device model clocks 11 falls and drives ACK low on the 11th. Required: ps2_clk_oe high for exactly INHIBIT_CYCLES+1 cycles; data_oe bit sequence (line level) 0,1,0,1,1,0,1,1,1,1(parity),1(stop); done with ack_err=0; busy low after done.
- Send 0x01; line levels after start are 1,0,0,0,0,0,0,0,0(parity),1. Device withholds ACK (line high) → done with ack_err=1.
- Pulse start again while busy mid-SEND with data=0xFF → ignored; frame still carries the original byte; exactly one done.
- Assert reset=0 at the 5th fall → both oe=0 within the same cycle (async); busy=0; the next start with 0xF4 completes normally.
- With PS2_TX_TIMEOUT_EN and TIMEOUT_CYCLES=100: device stops after 4 falls → 100 cycles later, oe=0, done=1, ack_err=1; without the macro, busy stays 1 for 10000 cycles.
- Glitch-free check: no falls during INHIBIT/REQ cause the counter to advance; the first device fall produces data bit 0 (data[0]).
